instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage. Owns the PC, presents it to a combinational
//   instruction memory and captures the returned word into the IF/ID register.
//   A three-state FSM (BOOT / RUN / HALT) sequences start-up after reset and
//   parks fetch when the PC leaves the instruction memory.
//
// Parameters
//   RESET_PC   first fetch byte address after reset
//   MEM_WORDS  instruction memory depth in 32-bit words
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset
//   stall_i        hazard stall from ID: hold PC and IF/ID
//   redirect_i     branch/jump taken: load PC from redirect_pc_i
//   redirect_pc_i  redirect target byte address (low two bits ignored)
//   instr_i        memory word for pc_addr_o (combinational return)
//   pc_addr_o      fetch byte address, equals the PC register
//   instr_o        IF/ID instruction
//   pc_plus4_o     IF/ID fetch address + 4
//   valid_o        IF/ID holds a real instruction
//   halted_o       fetch is parked on an out-of-range PC
//
// Optional feature (macro INSTR_FETCH_PERF_CNT_EN)
//   fetch_cnt_o    saturating count of valid IF/ID loads
//   bubble_cnt_o   saturating count of RUN/HALT cycles ending with valid_o=0,
//                  stall hold cycles excluded
//
// Handshake: there is no valid/ready pair on the memory side; instr_i is
// assumed valid in the same cycle pc_addr_o is presented. valid_o qualifies
// instr_o/pc_plus4_o toward ID, and ID back-pressures with stall_i only.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        halted_o
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // One bit wider than the PC so a full 4 GiB memory still compares correctly.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        pc_in_range;
  logic        target_in_range;

  // The two low target bits are dropped by word alignment.
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign pc_plus4        = pc_q + 32'd4;  // wraps modulo 2^32
  assign pc_in_range     = ({1'b0, pc_q} < PC_LIMIT);
  assign target_in_range = ({1'b0, redirect_target} < PC_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   Priority in RUN: redirect > out-of-range halt > stall > sequential fetch.
  //   pc_plus4_o is only written by a real fetch, so bubbles and halts leave
  //   the last link address in place.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    case (state_q)
      ST_BOOT: begin
        // Single settling cycle: IF/ID is never loaded here, but a redirect
        // already steers the first fetch.
        state_d = ST_RUN;
        if (redirect_i) begin
          pc_d = redirect_target;
        end
      end

      ST_RUN: begin
        if (redirect_i) begin
          pc_d    = redirect_target;
          instr_d = 32'd0;
          valid_d = 1'b0;
        end else if (!pc_in_range) begin
          state_d = ST_HALT;
          instr_d = 32'd0;
          valid_d = 1'b0;
        end else if (stall_i) begin
          // hold everything
        end else begin
          instr_d = instr_i;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end

      ST_HALT: begin
        // Stall is meaningless while parked; only a redirect moves the PC.
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (redirect_i) begin
          pc_d    = redirect_target;
          state_d = target_in_range ? ST_RUN : ST_HALT;
        end
      end

      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_PC;
        instr_d = 32'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // pc_addr_o depends on the PC flop only, never on instr_i.
  assign pc_addr_o  = pc_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;
  assign halted_o   = (state_q == ST_HALT);

`ifdef INSTR_FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        fetch_evt;
  logic        stall_hold;
  logic        bubble_evt;

  always_comb begin
    fetch_evt  = (state_q == ST_RUN) && !redirect_i && pc_in_range && !stall_i;
    // A stall hold keeps whatever valid_o was, so it is neither a fetch nor a
    // new bubble.
    stall_hold = (state_q == ST_RUN) && !redirect_i && pc_in_range && stall_i;
    bubble_evt = ((state_q == ST_RUN) || (state_q == ST_HALT)) &&
                 !stall_hold && !valid_d;

    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
